// File: rtl/pwm_multichan_gen.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty and
// polarity, duty/period double-buffered and swapped in only at a period boundary.

module pwm_lane #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DUTY = 64
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             xfer_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             pol_i,
  output logic             pwm_o
);
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    pend_d = wr_i   ? wr_data_i : pend_q;
    act_d  = xfer_i ? pend_q    : act_q;
    // Idle drives the inactive level, which is the polarity bit itself.
    pwm_d  = en_i ? ((cnt_i < act_q) ^ pol_i) : pol_i;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= WIDTH'(DEFAULT_DUTY);
      act_q  <= WIDTH'(DEFAULT_DUTY);
      pwm_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
endmodule

module pwm_multichan_gen #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int ADDR_W         = 2,
  parameter int DEFAULT_DUTY   = 64,
  parameter int DEFAULT_PERIOD = 255
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                en,
  input  logic                duty_wr,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                period_wr,
  input  logic [WIDTH-1:0]    period_in,
  input  logic [CHANNELS-1:0] pol_in,
  output logic [CHANNELS-1:0] PWM_out,
  output logic                cycle_start
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_pend_q, per_pend_d;
  logic [WIDTH-1:0] per_act_q, per_act_d;
  logic             cs_q, cs_d;
  logic             term, xfer;

  assign term = (cnt_q == per_act_q);
  // While idle, active config tracks pending so a restart uses the latest values.
  assign xfer = !en || term;

  always_comb begin
    cnt_d      = '0;
    cs_d       = 1'b0;
    per_pend_d = period_wr ? period_in : per_pend_q;
    per_act_d  = xfer ? per_pend_q : per_act_q;
    if (en) begin
      cnt_d = term ? '0 : cnt_q + WIDTH'(1);
      cs_d  = (cnt_q == '0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      per_pend_q <= WIDTH'(DEFAULT_PERIOD);
      per_act_q  <= WIDTH'(DEFAULT_PERIOD);
      cs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      per_pend_q <= per_pend_d;
      per_act_q  <= per_act_d;
      cs_q       <= cs_d;
    end
  end

  assign cycle_start = cs_q;

  // Out-of-range addresses match no lane, so they are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_lane #(
      .WIDTH        (WIDTH),
      .DEFAULT_DUTY (DEFAULT_DUTY)
    ) u_lane (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en_i      (en),
      .wr_i      (duty_wr && (wr_addr == ADDR_W'(i))),
      .wr_data_i (wr_data),
      .xfer_i    (xfer),
      .cnt_i     (cnt_q),
      .pol_i     (pol_in[i]),
      .pwm_o     (PWM_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multichan_gen.sv
// Bench for pwm_multichan_gen: cycle model of the period/duty rules plus
// per-window high-count checks for the directed scenarios and a random soak.

module tb_pwm_multichan_gen;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk_in = 1'b0;
  logic          rst_n, en, duty_wr, period_wr;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data, period_in;
  logic [CH-1:0] pol_in, PWM_out;
  logic          cycle_start;

  int total = 0;
  int bad   = 0;

  // Reference state: position in period, active/pending config.
  int            m_pos, m_per_act, m_per_pend;
  int            m_dact [CH];
  int            m_dpend[CH];
  logic [CH-1:0] m_pwm;
  logic          m_cs;

  // Window statistics gathered by run().
  int w_hi[CH];
  int w_cs, w_mis;

  pwm_multichan_gen #(
    .CHANNELS(CH), .WIDTH(W), .ADDR_W(AW), .DEFAULT_DUTY(64), .DEFAULT_PERIOD(255)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .duty_wr(duty_wr), .wr_addr(wr_addr),
    .wr_data(wr_data), .period_wr(period_wr), .period_in(period_in), .pol_in(pol_in),
    .PWM_out(PWM_out), .cycle_start(cycle_start)
  );

  always #5 clk_in = ~clk_in;

  task automatic mdl_reset();
    m_pos = 0; m_per_act = 255; m_per_pend = 255;
    for (int c = 0; c < CH; c++) begin m_dact[c] = 64; m_dpend[c] = 64; end
    m_pwm = '0; m_cs = 1'b0;
  endtask

  // Advance the reference by one clock using the inputs present now, then step the clock.
  task automatic tick();
    bool_load: begin
      bit load;
      load = 1'b0;
      if (rst_n) begin
        if (en) begin
          for (int c = 0; c < CH; c++) m_pwm[c] = (m_pos < m_dact[c]) ^ pol_in[c];
          m_cs = (m_pos == 0);
          if (m_pos >= m_per_act) begin m_pos = 0; load = 1'b1; end
          else m_pos = m_pos + 1;
        end else begin
          m_pwm = pol_in; m_cs = 1'b0; m_pos = 0; load = 1'b1;
        end
        if (load) begin
          m_per_act = m_per_pend;
          for (int c = 0; c < CH; c++) m_dact[c] = m_dpend[c];
        end
        if (duty_wr && int'(wr_addr) < CH) m_dpend[wr_addr] = int'(wr_data);
        if (period_wr) m_per_pend = int'(period_in);
      end
    end
    @(posedge clk_in); #1;
  endtask

  // Step n clocks; count high samples per channel, cycle_start pulses and model mismatches.
  task automatic run(input int n);
    for (int c = 0; c < CH; c++) w_hi[c] = 0;
    w_cs = 0; w_mis = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      for (int c = 0; c < CH; c++) w_hi[c] += int'(PWM_out[c]);
      w_cs += int'(cycle_start);
      if (PWM_out !== m_pwm || cycle_start !== m_cs) w_mis++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; duty_wr = 1'b0; period_wr = 1'b0;
    wr_addr = '0; wr_data = '0; period_in = '0; pol_in = 4'hF;
    mdl_reset();
    repeat (3) @(posedge clk_in);
    #1;
    total++;
    if (PWM_out !== 4'h0) begin bad++; $display("FAIL reset_pwm got=%b want=0000", PWM_out); end
    total++;
    if (cycle_start !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b want=0", cycle_start); end
    pol_in = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_default();
    for (int p = 0; p < 2; p++) begin
      run(256);
      total++;
      if (w_mis !== 0) begin bad++; $display("FAIL default_model mismatches=%0d want=0", w_mis); end
      total++;
      if (w_hi[0] !== 64 || w_hi[3] !== 64)
        begin bad++; $display("FAIL default_duty ch0=%0d ch3=%0d want=64", w_hi[0], w_hi[3]); end
      total++;
      if (w_cs !== 1) begin bad++; $display("FAIL default_cs got=%0d want=1", w_cs); end
    end
  endtask

  task automatic test_midwrite();
    int n = 0;
    int mis = 0;
    while (m_pos != 100 && n < 300) begin run(1); mis += w_mis; n++; end
    total++;
    if (m_pos != 100) begin bad++; $display("FAIL mid_wait timeout pos=%0d want=100", m_pos); end
    duty_wr = 1'b1; wr_addr = 3'd2; wr_data = 8'd128;
    run(1); mis += w_mis;
    duty_wr = 1'b0;
    run(155); mis += w_mis;
    total++;
    if (w_hi[2] !== 0 || w_cs !== 0)
      begin bad++; $display("FAIL mid_tail ch2=%0d cs=%0d want 0/0", w_hi[2], w_cs); end
    run(256); mis += w_mis;
    total++;
    if (w_hi[2] !== 128 || w_hi[0] !== 64)
      begin bad++; $display("FAIL mid_next ch2=%0d ch0=%0d want 128/64", w_hi[2], w_hi[0]); end
    total++;
    if (mis !== 0) begin bad++; $display("FAIL mid_model mismatches=%0d want=0", mis); end
  endtask

  task automatic test_idle_cfg();
    int mis = 0;
    en = 1'b0;
    run(1); mis += w_mis;
    total++;
    if (PWM_out !== 4'h0 || cycle_start !== 1'b0)
      begin bad++; $display("FAIL idle_out pwm=%b cs=%b want 0000/0", PWM_out, cycle_start); end
    period_wr = 1'b1; period_in = 8'd9; run(1); mis += w_mis; period_wr = 1'b0;
    duty_wr = 1'b1;
    wr_addr = 3'd0; wr_data = 8'd0;  run(1); mis += w_mis;
    wr_addr = 3'd1; wr_data = 8'd10; run(1); mis += w_mis;
    wr_addr = 3'd2; wr_data = 8'd3;  run(1); mis += w_mis;
    duty_wr = 1'b0;
    run(2); mis += w_mis;
    en = 1'b1;
    run(1); mis += w_mis;
    total++;
    if (cycle_start !== 1'b1) begin bad++; $display("FAIL restart_cs got=%b want=1", cycle_start); end
    run(9); mis += w_mis;
    run(10); mis += w_mis;
    total++;
    if (w_hi[0] !== 0 || w_hi[1] !== 10 || w_hi[2] !== 3 || w_hi[3] !== 10 || w_cs !== 1)
      begin bad++; $display("FAIL idle_cfg hi=%0d/%0d/%0d/%0d cs=%0d want 0/10/3/10 cs=1",
                            w_hi[0], w_hi[1], w_hi[2], w_hi[3], w_cs); end
    run(10); mis += w_mis;
    total++;
    if (mis !== 0) begin bad++; $display("FAIL idle_model mismatches=%0d want=0", mis); end
  endtask

  task automatic test_pol();
    int mis = 0;
    period_wr = 1'b1; period_in = 8'd255; run(1); mis += w_mis; period_wr = 1'b0;
    run(9); mis += w_mis;
    pol_in = 4'b1000;
    run(256); mis += w_mis;
    total++;
    if (w_hi[3] !== 192 || w_hi[1] !== 10 || w_cs !== 1)
      begin bad++; $display("FAIL pol_inv ch3=%0d ch1=%0d cs=%0d want 192/10/1", w_hi[3], w_hi[1], w_cs); end
    en = 1'b0;
    run(1); mis += w_mis;
    total++;
    if (PWM_out !== 4'b1000 || cycle_start !== 1'b0)
      begin bad++; $display("FAIL pol_idle pwm=%b cs=%b want 1000/0", PWM_out, cycle_start); end
    total++;
    if (mis !== 0) begin bad++; $display("FAIL pol_model mismatches=%0d want=0", mis); end
    pol_in = '0;
  endtask

  task automatic test_boundary();
    int n = 0;
    int mis = 0;
    run(2); mis += w_mis;
    en = 1'b1;
    duty_wr = 1'b1; wr_addr = 3'd5; wr_data = 8'd0; run(1); mis += w_mis; duty_wr = 1'b0;
    while (m_pos != m_per_act && n < 300) begin run(1); mis += w_mis; n++; end
    total++;
    if (m_pos != 255) begin bad++; $display("FAIL term_wait timeout pos=%0d want=255", m_pos); end
    duty_wr = 1'b1; wr_addr = 3'd1; wr_data = 8'd200; run(1); mis += w_mis; duty_wr = 1'b0;
    run(256); mis += w_mis;
    total++;
    if (w_hi[1] !== 10 || w_hi[0] !== 0)
      begin bad++; $display("FAIL term_hold ch1=%0d ch0=%0d want 10/0", w_hi[1], w_hi[0]); end
    run(256); mis += w_mis;
    total++;
    if (w_hi[1] !== 200 || w_hi[0] !== 0 || w_hi[2] !== 3 || w_hi[3] !== 64)
      begin bad++; $display("FAIL term_apply hi=%0d/%0d/%0d/%0d want 0/200/3/64",
                            w_hi[0], w_hi[1], w_hi[2], w_hi[3]); end
    total++;
    if (mis !== 0) begin bad++; $display("FAIL term_model mismatches=%0d want=0", mis); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    int mis = 0;
    while (m_pos != 37 && n < 300) begin run(1); mis += w_mis; n++; end
    total++;
    if (m_pos != 37) begin bad++; $display("FAIL ar_wait timeout pos=%0d want=37", m_pos); end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (PWM_out !== 4'h0 || cycle_start !== 1'b0)
      begin bad++; $display("FAIL ar_clear pwm=%b cs=%b want 0000/0", PWM_out, cycle_start); end
    mdl_reset();
    #2 rst_n = 1'b1;
    run(256); mis += w_mis;
    total++;
    if (w_hi[0] !== 64 || w_hi[1] !== 64 || w_hi[2] !== 64 || w_hi[3] !== 64 || w_cs !== 1)
      begin bad++; $display("FAIL ar_resume hi=%0d/%0d/%0d/%0d cs=%0d want 64 each cs=1",
                            w_hi[0], w_hi[1], w_hi[2], w_hi[3], w_cs); end
    total++;
    if (mis !== 0) begin bad++; $display("FAIL ar_model mismatches=%0d want=0", mis); end
  endtask

  task automatic test_random();
    int mis = 0;
    int ones = 0;
    for (int k = 0; k < 3000; k++) begin
      en        = ($urandom_range(0, 19) != 0);
      duty_wr   = ($urandom_range(0, 5) == 0);
      wr_addr   = AW'($urandom_range(0, 7));
      wr_data   = W'($urandom_range(0, 20));
      period_wr = ($urandom_range(0, 40) == 0);
      period_in = W'($urandom_range(0, 15));
      if ($urandom_range(0, 50) == 0) pol_in = CH'($urandom);
      run(1); mis += w_mis; ones += w_cs;
    end
    duty_wr = 1'b0; period_wr = 1'b0;
    total++;
    if (mis !== 0) begin bad++; $display("FAIL rand_model mismatches=%0d want=0", mis); end
    total++;
    if (ones == 0) begin bad++; $display("FAIL rand_cs pulses=%0d want>0", ones); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_midwrite();
    test_idle_cfg();
    test_pol();
    test_boundary();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
